// File: rtl/edge_encoder4to2.sv
// Encodes rising edges on four asynchronous event lines into 2-bit codes {b0,b1},
// buffering events as pending bits and presenting them through a valid/ready register.
module edge_encoder4to2 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic b0,
  output logic b1,
  output logic valid,
  input  logic ready,
  output logic overflow,
  input  logic clr_ovf
);

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic [3:0]                  d_in;
  logic [3:0][SYNC_STAGES-1:0] sync_q;
  logic [3:0]                  synced;
  logic [3:0]                  hist_q;
  logic [3:0]                  rise;

  logic [3:0] pending_q, pending_d;
  logic [3:0] grant;
  logic [1:0] grant_code;
  logic       load;
  logic       ovf_set;

  logic       state_q, state_d;
  logic [1:0] code_q, code_d;
  logic       ovf_q, ovf_d;

  assign d_in = {d3, d2, d1, d0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // History resets to 0, so a line already high at reset release yields one event.
  assign rise = synced & ~hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= (sync_q[i] << 1) | SYNC_STAGES'(d_in[i]);
      end
      hist_q <= synced;
    end
  end

  always_comb begin
    grant_code = 2'b00;
    if (pending_q[3]) begin
      grant_code = 2'b11;
    end else if (pending_q[2]) begin
      grant_code = 2'b10;
    end else if (pending_q[1]) begin
      grant_code = 2'b01;
    end
    load  = (state_q == StEmpty || ready) && (pending_q != 4'b0000);
    grant = load ? (4'b0001 << grant_code) : 4'b0000;
    // An edge on the line being granted this cycle re-arms it rather than merging.
    pending_d = (pending_q & ~grant) | rise;
    ovf_set   = |(rise & pending_q & ~grant);
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (load) begin
      state_d = StFull;
      code_d  = grant_code;
    end else if (state_q == StFull && ready) begin
      state_d = StEmpty;
    end
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      state_q   <= StEmpty;
      code_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      code_q    <= code_d;
      ovf_q     <= ovf_d;
    end
  end

  assign valid    = (state_q == StFull);
  assign b0       = code_q[1];
  assign b1       = code_q[0];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_encoder4to2.sv
// Randomized and directed bench for edge_encoder4to2 against a cycle-level behavioural model.
module tb_edge_encoder4to2;

  localparam int S = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] dv;
  logic       ready;
  logic       clr_ovf;
  logic       b0, b1, valid, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: per-line sample history (index j = sampled j+1 edges ago), pending set, output.
  bit         mh [4][S+1];
  bit         m_pend [4];
  bit         m_valid;
  logic [1:0] m_code;
  bit         m_ovf;

  edge_encoder4to2 #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d0       (dv[0]),
    .d1       (dv[1]),
    .d2       (dv[2]),
    .d3       (dv[3]),
    .b0       (b0),
    .b1       (b1),
    .valid    (valid),
    .ready    (ready),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dut_vec();
    return {valid, b0, b1, overflow};
  endfunction

  function automatic logic [3:0] model_vec();
    return {m_valid, m_code, m_ovf};
  endfunction

  task automatic model_step();
    bit rise [4];
    int hi;
    bit load;
    bit ovf_set;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j <= S; j++) mh[i][j] = 1'b0;
        m_pend[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_code  = 2'b00;
      m_ovf   = 1'b0;
      return;
    end
    // A line's rising edge becomes visible S edges after it was sampled.
    for (int i = 0; i < 4; i++) rise[i] = mh[i][S-1] && !mh[i][S];
    for (int i = 0; i < 4; i++) begin
      for (int j = S; j >= 1; j--) mh[i][j] = mh[i][j-1];
      mh[i][0] = dv[i];
    end
    hi = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i]) hi = i;
    load    = (!m_valid || ready) && (hi >= 0);
    ovf_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit granted;
      granted = load && (hi == i);
      if (rise[i] && m_pend[i] && !granted) ovf_set = 1'b1;
      m_pend[i] = (m_pend[i] && !granted) || rise[i];
    end
    if (load) begin
      m_valid = 1'b1;
      m_code  = 2'(hi);
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL model t=%0t: dut {valid,b0,b1,ovf}=%b, model requires %b",
               $time, dut_vec(), model_vec());
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_lit(input string name, input logic [3:0] exp);
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL %s: dut {valid,b0,b1,ovf}=%b, required %b", name, dut_vec(), exp);
    end
    n_checks++;
    if (model_vec() !== exp) begin
      n_fail++;
      $display("FAIL %s_model: model {valid,b0,b1,ovf}=%b, required %b", name, model_vec(), exp);
    end
  endtask

  initial begin
    int hold [4];
    rst_n   = 1'b0;
    dv      = 4'b1000;
    ready   = 1'b1;
    clr_ovf = 1'b0;

    // Line held high through reset release yields exactly one 11 code.
    steps(3);
    check_lit("reset_state", 4'b0000);
    rst_n = 1'b1;
    steps(3);
    check_lit("reset_latency", 4'b0000);
    step();
    check_lit("reset_d3_event", 4'b1110);
    for (int k = 0; k < 10; k++) begin
      step();
      check_lit("reset_no_repeat", 4'b0110);
    end
    dv = 4'b0000;
    steps(3);

    // Single events with ready tied high.
    for (int line = 0; line < 4; line++) begin
      logic [1:0] code, prev;
      code = 2'(line);
      prev = (line == 0) ? 2'b11 : 2'(line - 1);
      for (int k = 1; k <= 14; k++) begin
        dv[line] = (k <= 4);
        step();
        if (k == 3) check_lit("single_before", {1'b0, prev, 1'b0});
        if (k == 4) check_lit("single_valid", {1'b1, code, 1'b0});
        if (k == 5) check_lit("single_after", {1'b0, code, 1'b0});
      end
    end

    // Simultaneous edges under backpressure drain in priority order.
    ready = 1'b0;
    dv    = 4'hF;
    steps(4);
    check_lit("simul_first", 4'b1110);
    steps(2);
    check_lit("simul_held", 4'b1110);
    dv    = 4'h0;
    ready = 1'b1;
    step();
    check_lit("simul_10", 4'b1100);
    step();
    check_lit("simul_01", 4'b1010);
    step();
    check_lit("simul_00", 4'b1000);
    step();
    check_lit("simul_drained", 4'b0000);

    // Overflow: output occupied by 11, two d1 events merge into one.
    ready = 1'b0;
    dv    = 4'b1000;
    steps(4);
    dv = 4'b0000;
    steps(4);
    for (int k = 0; k < 16; k++) begin
      dv[1] = (k < 4) || (k >= 8 && k < 12);
      step();
    end
    check_lit("ovf_set", 4'b1111);
    ready = 1'b1;
    step();
    check_lit("ovf_deliver_01", 4'b1011);
    step();
    check_lit("ovf_once", 4'b0011);
    step();
    check_lit("ovf_once_more", 4'b0011);
    clr_ovf = 1'b1;
    step();
    check_lit("ovf_cleared", 4'b0010);
    clr_ovf = 1'b0;
    step();
    check_lit("ovf_stays_clear", 4'b0010);

    // Second d2 edge coincides with the grant of d2: delivered twice, no overflow.
    ready = 1'b0;
    dv    = 4'b1000;
    steps(4);
    dv = 4'b0000;
    steps(4);
    for (int k = 0; k < 14; k++) begin
      dv[2] = (k < 4) || (k >= 8 && k < 12);
      ready = (k >= 10);
      step();
      if (k == 10) check_lit("coinc_first_10", 4'b1100);
      if (k == 11) check_lit("coinc_second_10", 4'b1100);
      if (k == 12) check_lit("coinc_done", 4'b0100);
    end

    // Mid-operation reset discards held and pending events.
    ready = 1'b0;
    dv    = 4'b0101;
    steps(4);
    dv = 4'b0000;
    steps(4);
    check_lit("midrst_before", 4'b1100);
    rst_n = 1'b0;
    step();
    check_lit("midrst_in_reset", 4'b0000);
    rst_n = 1'b1;
    ready = 1'b1;
    steps(10);
    check_lit("midrst_nothing", 4'b0000);

    // Randomized traffic; each line holds a level for at least 2 clocks.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          dv[i]   = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(2, 7));
        end
        hold[i]--;
      end
      ready   = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 599) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
